// File: rtl/ip_arb_pkg.sv
// Shared defines for the integer-pipe issue arbiter: requester indices, default
// micro-op bundle width and branch-type encodings carried in the bundle.
package ip_arb_pkg;

  localparam int UOP_W_DEF = 192;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

  localparam logic [2:0] BT_NONE = 3'd0;
  localparam logic [2:0] BT_COND = 3'd1;
  localparam logic [2:0] BT_JUMP = 3'd2;
  localparam logic [2:0] BT_CALL = 3'd3;
  localparam logic [2:0] BT_RET  = 3'd4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin select with a pointer that advances only on a transfer.
// A lone valid requester always wins; on a tie the pointer decides.
module rr_arb2
  import ip_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic sel
);

  logic rr;

  always_comb begin
    sel = SRC_REQ0;
    if (valid0 && valid1) begin
      sel = rr;
    end else if (valid1) begin
      sel = SRC_REQ1;
    end
  end

  // Pointer moves to the loser so a waiting requester wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= SRC_REQ0;
    end else if (advance) begin
      rr <= ~sel;
    end
  end

endmodule

// File: rtl/ip_arb.sv
// Arbitrates two micro-op requesters onto the integer pipe with saturating grant counters.
// Build option IP_ARB_OUTREG_EN adds a registered output stage (one cycle latency); default is combinational.
module ip_arb
  import ip_arb_pkg::*;
#(
  parameter int UOP_W = UOP_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [UOP_W-1:0] req0_uop,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [UOP_W-1:0] req1_uop,
  output logic             req1_ready,
  output logic             ip_valid,
  output logic [UOP_W-1:0] ip_uop,
  output logic             ip_src,
  input  logic             ip_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  logic sel;
  logic grant_ok;
  logic xfer0;
  logic xfer1;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .advance (xfer0 | xfer1),
    .sel     (sel)
  );

`ifdef IP_ARB_OUTREG_EN
  logic             stage_vld;
  logic [UOP_W-1:0] stage_uop;
  logic             stage_src;

  // Skid stage: accept a new uop whenever the current one leaves this cycle.
  assign grant_ok = (~stage_vld | ip_ready) & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stage_vld <= 1'b0;
    end else if (xfer0 || xfer1) begin
      stage_vld <= 1'b1;
      stage_uop <= (sel == SRC_REQ1) ? req1_uop : req0_uop;
      stage_src <= sel;
    end else if (ip_ready) begin
      stage_vld <= 1'b0;
    end
  end

  assign ip_valid = stage_vld & ~rst;
  assign ip_uop   = stage_uop;
  assign ip_src   = stage_src;
`else
  assign grant_ok = ip_ready & ~flush & ~rst;
  assign ip_valid = (req0_valid | req1_valid) & ~flush & ~rst;
  assign ip_uop   = (sel == SRC_REQ1) ? req1_uop : req0_uop;
  assign ip_src   = sel;
`endif

  assign req0_ready = grant_ok & (sel == SRC_REQ0);
  assign req1_ready = grant_ok & (sel == SRC_REQ1);
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (xfer0 && (grant_cnt0 != {CNT_W{1'b1}})) begin
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end
      if (xfer1 && (grant_cnt1 != {CNT_W{1'b1}})) begin
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ip_arb.sv
// Directed bench for ip_arb in its default combinational configuration, plus a
// narrow-counter instance for saturation.
module tb_ip_arb;

  localparam int UW = 192;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, ip_ready, flush;
  logic [UW-1:0] req0_uop, req1_uop;
  logic          req0_ready, req1_ready, ip_valid, ip_src;
  logic [UW-1:0] ip_uop;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  logic          s_rst, s_req0_valid, s_req1_valid, s_ip_ready, s_flush;
  logic [7:0]    s_req0_uop, s_req1_uop, s_ip_uop;
  logic          s_req0_ready, s_req1_ready, s_ip_valid, s_ip_src;
  logic [3:0]    s_cnt0, s_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ip_arb #(.UOP_W(UW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_uop   (req0_uop),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_uop   (req1_uop),
    .req1_ready (req1_ready),
    .ip_valid   (ip_valid),
    .ip_uop     (ip_uop),
    .ip_src     (ip_src),
    .ip_ready   (ip_ready),
    .flush      (flush),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  ip_arb #(.UOP_W(8), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .rst        (s_rst),
    .req0_valid (s_req0_valid),
    .req0_uop   (s_req0_uop),
    .req0_ready (s_req0_ready),
    .req1_valid (s_req1_valid),
    .req1_uop   (s_req1_uop),
    .req1_ready (s_req1_ready),
    .ip_valid   (s_ip_valid),
    .ip_uop     (s_ip_uop),
    .ip_src     (s_ip_src),
    .ip_ready   (s_ip_ready),
    .flush      (s_flush),
    .grant_cnt0 (s_cnt0),
    .grant_cnt1 (s_cnt1)
  );

  task automatic check(input string tag, input logic [UW-1:0] got, input logic [UW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ip_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_uop = UW'(32'h100); req1_uop = UW'(32'h200);
    s_rst = 1'b1; s_flush = 1'b0; s_ip_ready = 1'b1;
    s_req0_valid = 1'b1; s_req1_valid = 1'b0;
    s_req0_uop = 8'h3C; s_req1_uop = 8'h00;

    // Reset holds everything quiet even with requests pending.
    cyc(); cyc();
    check("rst_ip_valid", UW'(ip_valid), UW'(0));
    check("rst_req0_ready", UW'(req0_ready), UW'(0));
    check("rst_req1_ready", UW'(req1_ready), UW'(0));
    check("rst_cnt0", UW'(grant_cnt0), UW'(0));
    check("rst_cnt1", UW'(grant_cnt1), UW'(0));

    // Both valid, pipe ready: strict alternation starting with requester 0.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("alt_src%0d", i), UW'(ip_src), UW'(i % 2));
      check($sformatf("alt_r0rdy%0d", i), UW'(req0_ready), UW'((i % 2) == 0));
      check($sformatf("alt_r1rdy%0d", i), UW'(req1_ready), UW'((i % 2) == 1));
      check($sformatf("alt_uop%0d", i), ip_uop, (i % 2) ? UW'(32'h200) : UW'(32'h100));
      cyc();
    end
    check("alt_cnt0", UW'(grant_cnt0), UW'(2));
    check("alt_cnt1", UW'(grant_cnt1), UW'(2));

    // Only requester 1 valid.
    req0_valid = 1'b0; req1_uop = UW'(32'hA5);
    #1;
    check("solo1_valid", UW'(ip_valid), UW'(1));
    check("solo1_uop", ip_uop, UW'(32'hA5));
    check("solo1_src", UW'(ip_src), UW'(1));
    check("solo1_r0rdy", UW'(req0_ready), UW'(0));
    cyc();
    check("solo1_cnt1", UW'(grant_cnt1), UW'(3));

    // Flush while both valid: no transfer, pointer (now 0) holds.
    req0_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_r0rdy", UW'(req0_ready), UW'(0));
    check("flush_r1rdy", UW'(req1_ready), UW'(0));
    check("flush_ip_valid", UW'(ip_valid), UW'(0));
    cyc();
    flush = 1'b0;
    #1;
    check("flush_cnt0", UW'(grant_cnt0), UW'(2));
    check("flush_cnt1", UW'(grant_cnt1), UW'(3));
    check("post_flush_src", UW'(ip_src), UW'(0));
    cyc();
    check("post_flush_cnt0", UW'(grant_cnt0), UW'(3));

    // Pointer now 1; hold a uop from requester 1, then reset over it.
    ip_ready = 1'b0;
    #1;
    check("hold_src_rr1", UW'(ip_src), UW'(1));
    cyc();
    rst = 1'b1;
    #1;
    check("rst_mid_valid", UW'(ip_valid), UW'(0));
    check("rst_mid_r1rdy", UW'(req1_ready), UW'(0));
    cyc();
    rst = 1'b0;
    #1;
    check("rst_mid_cnt0", UW'(grant_cnt0), UW'(0));
    check("rst_mid_cnt1", UW'(grant_cnt1), UW'(0));
    check("rst_rr0_src", UW'(ip_src), UW'(0));

    // Pipe stalled for three cycles with requester 0's uop held.
    req1_valid = 1'b0; req0_uop = UW'(32'h11);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_uop%0d", i), ip_uop, UW'(32'h11));
      check($sformatf("stall_valid%0d", i), UW'(ip_valid), UW'(1));
      check($sformatf("stall_r0rdy%0d", i), UW'(req0_ready), UW'(0));
      cyc();
    end
    check("stall_cnt0", UW'(grant_cnt0), UW'(0));
    ip_ready = 1'b1;
    #1;
    check("release_r0rdy", UW'(req0_ready), UW'(1));
    cyc();
    req0_valid = 1'b0;
    #1;
    check("release_cnt0", UW'(grant_cnt0), UW'(1));
    cyc();
    check("idle_cnt0", UW'(grant_cnt0), UW'(1));

    // Narrow counter saturates at 15 without wrapping.
    s_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 9) check("sat_cnt0_mid", UW'(s_cnt0), UW'(10));
    end
    check("sat_cnt0", UW'(s_cnt0), UW'(15));
    check("sat_cnt1", UW'(s_cnt1), UW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ip_arb.md
IP_ARB -- requirements
Module: ip_arb

Interface
REQ-001 SHALL have parameter UOP_W, default 192, width of the packed integer-pipe micro-op bundle (pc, dst, op, operands, branch fields).
REQ-002 SHALL have parameter CNT_W, default 16, width of per-requester grant counters.
REQ-003 SHALL have ports: clk  input  1  clock; rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req0_valid  input  1  requester 0 offers uop; req0_uop  input  UOP_W  requester 0 bundle; req0_ready  output  1  requester 0 accepted.
REQ-005 SHALL have ports: req1_valid  input  1; req1_uop  input  UOP_W; req1_ready  output  1 (same meaning for requester 1).
REQ-006 SHALL have ports: ip_valid  output  1  uop to integer pipe valid; ip_uop  output  UOP_W  bundle to pipe; ip_src  output  1  index of source requester; ip_ready  input  1  pipe accepts.
REQ-007 SHALL have ports: flush  input  1  pipe redirect (pc override), kill pending uop; grant_cnt0 / grant_cnt1  output  CNT_W  saturating accepted-transfer counts.

Function
REQ-008 Transfer on a port SHALL occur only in a cycle where its valid and ready are both high.
REQ-009 When only one requester is valid, it SHALL be selected.
REQ-010 When both are valid, the requester equal to round-robin pointer rr SHALL be selected.
REQ-011 rr SHALL update to the non-selected index only in a cycle where a requester transfer occurs; otherwise hold.
REQ-012 At most one of req0_ready/req1_ready SHALL be high in any cycle; the non-selected requester's ready SHALL be low.
REQ-013 A requester's valid-high uop SHALL NOT be starved: with both valid and ip_ready continuously high, grants SHALL strictly alternate.
REQ-014 In a flush cycle, req0_ready and req1_ready SHALL be low, no transfer occurs, rr holds.
REQ-015 Counter grant_cntN SHALL increment by 1 per requester-N transfer and saturate at 2^CNT_W-1 (no wrap).
REQ-016 ip_src SHALL equal index of the requester whose uop is on ip_uop; ip_uop/ip_src SHALL be don't-care when ip_valid low.
REQ-017 An output uop held with ip_valid high and ip_ready low SHALL remain stable (uop, src) until accepted or flushed.

Reset
REQ-018 During rst: ip_valid=0, req0_ready=0, req1_ready=0, rr=0, grant_cnt0=0, grant_cnt1=0, held output register empty.
REQ-019 rst asserted mid-transfer SHALL discard any held uop; first cycle after rst deasserts SHALL arbitrate normally with rr=0.
REQ-020 rst SHALL take priority over flush and over any handshake.

Configuration
REQ-021 Macro IP_ARB_OUTREG_EN defined: output SHALL be a registered skid stage; uop appears on ip_valid/ip_uop one cycle after requester transfer; requester ready = (stage empty or ip_ready) and not flush; flush clears stage next cycle; back-to-back throughput one uop/cycle.
REQ-022 IP_ARB_OUTREG_EN undefined: path SHALL be combinational, zero latency; ip_valid = (req0_valid or req1_valid) and not flush; selected ready = ip_ready and not flush; no output storage.
REQ-023 Arbitration, counters and rr SHALL behave identically in both configurations apart from latency.

Structure
REQ-024 Requester-index constants (SRC_REQ0=0, SRC_REQ1=1) and UOP_W default SHALL live in the shared defines header alongside BT_* constants.
REQ-025 A single sub-module rr_arb2 (2-way round-robin select + pointer) SHALL be instantiated; counters and output stage stay in ip_arb.

Verification
REQ-026 Both valid continuously, ip_ready=1, rr=0 after reset -> grants 0,1,0,1; grant_cnt0=grant_cnt1=2 after 4 transfers.
REQ-027 Only req1 valid with uop 0xA5, ip_ready=1 -> ip_uop=0xA5, ip_src=1 (same cycle, or next cycle with OUTREG_EN); req0_ready=0.
REQ-028 ip_ready=0 for 3 cycles with req0 uop 0x11 held -> ip_uop stays 0x11, no counter change; ip_ready=1 -> single transfer, grant_cnt0=1.
REQ-029 flush pulse while both valid -> both readies 0 that cycle, rr unchanged, (OUTREG_EN) held uop dropped, ip_valid=0 next cycle.
REQ-030 CNT_W=4, req0 alone for 20 transfers -> grant_cnt0=15 saturated, grant_cnt1=0.
REQ-031 rst asserted with held uop and rr=1 -> ip_valid=0, rr=0, counters 0 next cycle; both valid after release -> requester 0 granted first.
